// File: rtl/m_axil_rw.sv
// AXI4-Lite master with one outstanding read or write command, a registered
// completion port and a saturating count of non-OKAY responses.
module m_axil_rw #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_wr,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [DATA_W-1:0]     i_cmd_data,
  input  logic [DATA_W/8-1:0]   i_cmd_strb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_wr,
  output logic [DATA_W-1:0]     o_rsp_data,
  output logic [1:0]            o_rsp_resp,
  output logic [ERRCNT_W-1:0]   o_err_cnt,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  // state   | meaning
  // IDLE    | cmd_ready high, waiting for a command
  // WR_REQ  | AW and W each held until their own handshake
  // WR_RESP | bready high, waiting for B
  // RD_REQ  | arvalid high, waiting for arready
  // RD_RESP | rready high, waiting for R
  // RSP     | completion held until consumed
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                state, state_d;
  logic                  cmd_ready_d, rsp_valid_d, rsp_wr_d;
  logic [DATA_W-1:0]     rsp_data_d, wdata_d;
  logic [1:0]            rsp_resp_d;
  logic [ERRCNT_W-1:0]   err_cnt_d;
  logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [ADDR_W-1:0]     awaddr_d, araddr_d;
  logic [DATA_W/8-1:0]   wstrb_d;
  logic                  err_hit;
  logic                  aw_done, w_done;

  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  always_comb begin
    state_d     = state;
    cmd_ready_d = o_cmd_ready;
    rsp_valid_d = o_rsp_valid;
    rsp_wr_d    = o_rsp_wr;
    rsp_data_d  = o_rsp_data;
    rsp_resp_d  = o_rsp_resp;
    awvalid_d   = m_axi_awvalid;
    awaddr_d    = m_axi_awaddr;
    wvalid_d    = m_axi_wvalid;
    wdata_d     = m_axi_wdata;
    wstrb_d     = m_axi_wstrb;
    bready_d    = m_axi_bready;
    arvalid_d   = m_axi_arvalid;
    araddr_d    = m_axi_araddr;
    rready_d    = m_axi_rready;
    err_hit     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (i_cmd_valid && o_cmd_ready) begin
          cmd_ready_d = 1'b0;
          if (i_cmd_wr) begin
            awaddr_d  = i_cmd_addr;
            wdata_d   = i_cmd_data;
            wstrb_d   = i_cmd_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = i_cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wvalid && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid && m_axi_bready) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi_bresp;
          rsp_wr_d    = 1'b1;
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          err_hit     = (m_axi_bresp != 2'b00);
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (m_axi_arvalid && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid && m_axi_rready) begin
          rready_d    = 1'b0;
          rsp_resp_d  = m_axi_rresp;
          rsp_wr_d    = 1'b0;
          rsp_data_d  = m_axi_rdata;
          rsp_valid_d = 1'b1;
          err_hit     = (m_axi_rresp != 2'b00);
          state_d     = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_cnt_d = (err_hit && (o_err_cnt != {ERRCNT_W{1'b1}})) ? o_err_cnt + 1'b1 : o_err_cnt;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state         <= IDLE;
      o_cmd_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_wr      <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_resp    <= '0;
      o_err_cnt     <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      state         <= state_d;
      o_cmd_ready   <= cmd_ready_d;
      o_rsp_valid   <= rsp_valid_d;
      o_rsp_wr      <= rsp_wr_d;
      o_rsp_data    <= rsp_data_d;
      o_rsp_resp    <= rsp_resp_d;
      o_err_cnt     <= err_cnt_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wstrb   <= wstrb_d;
      m_axi_bready  <= bready_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_araddr  <= araddr_d;
      m_axi_rready  <= rready_d;
    end
  end

endmodule

// File: tb/tb_m_axil_rw.sv
// Directed bench for m_axil_rw; a 2-bit error counter makes saturation reachable.
module tb_m_axil_rw;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ERRCNT_W = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cmd_valid = 0, cmd_ready, cmd_wr = 0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [DATA_W/8-1:0] cmd_strb = '0;
  logic rsp_valid, rsp_ready = 0, rsp_wr;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0] rsp_resp;
  logic [ERRCNT_W-1:0] err_cnt;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [DATA_W-1:0] wdata, rdata = '0;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0] bresp = 0, rresp = 0;
  logic arvalid, arready = 0, rvalid = 0, rready;

  int n_vec = 0;
  int n_err = 0;

  m_axil_rw #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERRCNT_W(ERRCNT_W)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_strb(cmd_strb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_wr(rsp_wr),
    .o_rsp_data(rsp_data), .o_rsp_resp(rsp_resp), .o_err_cnt(err_cnt),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = '0;
  endtask

  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_data = d; cmd_strb = s;
    tick();
    cmd_valid = 0;
  endtask

  task automatic consume();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    logic [159:0] all_out;
    repeat (2) tick();
    all_out = {cmd_ready, rsp_valid, rsp_wr, rsp_data, rsp_resp, err_cnt, awvalid, awaddr,
               wvalid, wdata, wstrb, bready, arvalid, araddr, rready};
    n_vec++;
    if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs got=%h want=0", all_out); end
    resetn = 1;
    tick();
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    n_vec++;
    if (err_cnt !== 2'd0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_idle err_cnt=%0d rsp_valid=%b want 0/0", err_cnt, rsp_valid);
    end
  endtask

  task automatic test_write_fast();
    awready = 1; wready = 1; bvalid = 1; bresp = 0;
    issue(1, 32'h10, 32'h5, 4'hF);
    n_vec++;
    if ({awvalid, wvalid, cmd_ready} !== 3'b110 || awaddr !== 32'h10 || wdata !== 32'h5 || wstrb !== 4'hF) begin
      n_err++;
      $display("FAIL wr_fast_req aw/w/rdy=%b%b%b addr=%h data=%h strb=%h want 110 10 5 f",
               awvalid, wvalid, cmd_ready, awaddr, wdata, wstrb);
    end
    tick();
    n_vec++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      n_err++; $display("FAIL wr_fast_n1 aw/w/bready=%b%b%b want 001", awvalid, wvalid, bready);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1 || rsp_wr !== 1 || rsp_resp !== 2'b00 || rsp_data !== 32'h0 || err_cnt !== 2'd0 || bready !== 0) begin
      n_err++;
      $display("FAIL wr_fast_rsp valid=%b wr=%b resp=%b data=%h err=%0d bready=%b want 1 1 00 0 0 0",
               rsp_valid, rsp_wr, rsp_resp, rsp_data, err_cnt, bready);
    end
    consume();
    n_vec++;
    if (rsp_valid !== 0 || cmd_ready !== 1) begin
      n_err++; $display("FAIL wr_fast_done rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
    end
    slave_idle();
  endtask

  task automatic test_write_wait();
    awready = 1; wready = 0; bvalid = 1; bresp = 0;
    issue(1, 32'h20, 32'hDEADBEEF, 4'h3);
    tick();
    n_vec++;
    if ({awvalid, wvalid, bready} !== 3'b010 || wdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_wait_n1 aw/w/b=%b%b%b wdata=%h want 010 deadbeef", awvalid, wvalid, bready, wdata);
    end
    for (int i = 2; i <= 3; i++) begin
      tick();
      n_vec++;
      if ({awvalid, wvalid, bready} !== 3'b010 || wdata !== 32'hDEADBEEF || wstrb !== 4'h3) begin
        n_err++;
        $display("FAIL wr_wait_hold cyc=%0d aw/w/b=%b%b%b wdata=%h strb=%h want 010 deadbeef 3",
                 i, awvalid, wvalid, bready, wdata, wstrb);
      end
    end
    wready = 1;
    tick();
    wready = 0;
    n_vec++;
    if ({wvalid, bready} !== 2'b01) begin
      n_err++; $display("FAIL wr_wait_n4 wvalid/bready=%b%b want 01", wvalid, bready);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1 || rsp_wr !== 1 || rsp_resp !== 2'b00) begin
      n_err++; $display("FAIL wr_wait_rsp valid=%b wr=%b resp=%b want 1 1 00", rsp_valid, rsp_wr, rsp_resp);
    end
    consume();
    slave_idle();
  endtask

  task automatic test_read();
    arready = 1;
    issue(0, 32'h8, 32'hFFFF_FFFF, 4'hF);
    n_vec++;
    if (arvalid !== 1 || araddr !== 32'h8 || awvalid !== 0 || wvalid !== 0) begin
      n_err++; $display("FAIL rd_req arvalid=%b araddr=%h aw=%b w=%b want 1 8 0 0", arvalid, araddr, awvalid, wvalid);
    end
    tick();
    n_vec++;
    if ({arvalid, rready} !== 2'b01) begin
      n_err++; $display("FAIL rd_ar arvalid/rready=%b%b want 01", arvalid, rready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (rready !== 1 || rsp_valid !== 0) begin
        n_err++; $display("FAIL rd_wait cyc=%0d rready=%b rsp_valid=%b want 1 0", i, rready, rsp_valid);
      end
    end
    rvalid = 1; rdata = 32'hA5A5_0001; rresp = 0;
    tick();
    rvalid = 0;
    n_vec++;
    if (rsp_valid !== 1 || rsp_data !== 32'hA5A5_0001 || rsp_wr !== 0 || rsp_resp !== 2'b00 || rready !== 0) begin
      n_err++;
      $display("FAIL rd_rsp valid=%b data=%h wr=%b resp=%b rready=%b want 1 a5a50001 0 00 0",
               rsp_valid, rsp_data, rsp_wr, rsp_resp, rready);
    end
    consume();
    slave_idle();
  endtask

  task automatic test_errors();
    logic [1:0] exp_resp;
    logic [1:0] exp_cnt;
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
    arready = 1; rvalid = 1; rresp = 2'b11; rdata = 32'h0BAD_0000;
    for (int i = 0; i < 5; i++) begin
      exp_resp = (i % 2 == 0) ? 2'b10 : 2'b11;
      exp_cnt  = (i >= 2) ? 2'd3 : 2'(i + 1);
      issue((i % 2 == 0), 32'h100 + 32'(i), 32'h0, 4'h1);
      repeat (2) tick();
      n_vec++;
      if (rsp_valid !== 1 || rsp_resp !== exp_resp || err_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL err_resp n=%0d valid=%b resp=%b err_cnt=%0d want 1 %b %0d",
                 i, rsp_valid, rsp_resp, err_cnt, exp_resp, exp_cnt);
      end
      consume();
    end
    slave_idle();
  endtask

  task automatic test_rsp_hold();
    arready = 1;
    issue(0, 32'h30, 32'h0, 4'h0);
    rvalid = 1; rdata = 32'h1234_5678; rresp = 0;
    repeat (2) tick();
    n_vec++;
    if (rsp_valid !== 1 || rsp_data !== 32'h1234_5678) begin
      n_err++; $display("FAIL hold_start valid=%b data=%h want 1 12345678", rsp_valid, rsp_data);
    end
    cmd_valid = 1; cmd_wr = 1; awready = 1; wready = 1; bvalid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (rsp_valid !== 1 || rsp_data !== 32'h1234_5678 || rsp_wr !== 0 || rsp_resp !== 2'b00 ||
          err_cnt !== 2'd3 || cmd_ready !== 0 ||
          {awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
        n_err++;
        $display("FAIL hold cyc=%0d valid=%b data=%h wr=%b resp=%b cnt=%0d rdy=%b axi=%b%b%b%b%b",
                 i, rsp_valid, rsp_data, rsp_wr, rsp_resp, err_cnt, cmd_ready,
                 awvalid, wvalid, arvalid, bready, rready);
      end
    end
    cmd_valid = 0;
    consume();
    slave_idle();
  endtask

  task automatic test_back_to_back();
    awready = 1; wready = 1; bvalid = 1; arready = 1; rvalid = 1; rdata = 32'hCAFE_0001;
    rsp_ready = 1;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 32'h40; cmd_data = 32'h11; cmd_strb = 4'h1;
    tick();
    cmd_wr = 0; cmd_addr = 32'h44;
    tick();
    n_vec++;
    if (cmd_ready !== 0 || bready !== 1) begin
      n_err++; $display("FAIL b2b_n1 cmd_ready=%b bready=%b want 0 1", cmd_ready, bready);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1 || rsp_wr !== 1 || cmd_ready !== 0) begin
      n_err++; $display("FAIL b2b_n2 valid=%b wr=%b cmd_ready=%b want 1 1 0", rsp_valid, rsp_wr, cmd_ready);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 0 || cmd_ready !== 1 || arvalid !== 0) begin
      n_err++; $display("FAIL b2b_n3 valid=%b cmd_ready=%b arvalid=%b want 0 1 0", rsp_valid, cmd_ready, arvalid);
    end
    tick();
    cmd_valid = 0;
    n_vec++;
    if (arvalid !== 1 || araddr !== 32'h44 || cmd_ready !== 0) begin
      n_err++; $display("FAIL b2b_n4 arvalid=%b araddr=%h cmd_ready=%b want 1 44 0", arvalid, araddr, cmd_ready);
    end
    repeat (2) tick();
    n_vec++;
    if (rsp_valid !== 1 || rsp_wr !== 0 || rsp_data !== 32'hCAFE_0001) begin
      n_err++; $display("FAIL b2b_rd valid=%b wr=%b data=%h want 1 0 cafe0001", rsp_valid, rsp_wr, rsp_data);
    end
    tick();
    rsp_ready = 0;
    n_vec++;
    if (rsp_valid !== 0 || cmd_ready !== 1) begin
      n_err++; $display("FAIL b2b_done valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
    end
    slave_idle();
  endtask

  task automatic test_reset_mid();
    logic [159:0] all_out;
    issue(1, 32'h80, 32'h77, 4'hF);
    n_vec++;
    if (awvalid !== 1 || wvalid !== 1) begin
      n_err++; $display("FAIL rst_mid_pre aw=%b w=%b want 1 1", awvalid, wvalid);
    end
    #2 resetn = 0;
    #1;
    all_out = {cmd_ready, rsp_valid, rsp_wr, rsp_data, rsp_resp, err_cnt, awvalid, awaddr,
               wvalid, wdata, wstrb, bready, arvalid, araddr, rready};
    n_vec++;
    if (all_out !== '0) begin n_err++; $display("FAIL rst_mid_async got=%h want=0", all_out); end
    #1 resetn = 1;
    tick();
    n_vec++;
    if (cmd_ready !== 1 || err_cnt !== 2'd0 || awvalid !== 0) begin
      n_err++; $display("FAIL rst_mid_release cmd_ready=%b err=%0d aw=%b want 1 0 0", cmd_ready, err_cnt, awvalid);
    end
    arready = 1;
    issue(0, 32'h90, 32'h0, 4'h0);
    n_vec++;
    if (arvalid !== 1 || awvalid !== 0 || araddr !== 32'h90) begin
      n_err++; $display("FAIL rst_mid_idle arvalid=%b awvalid=%b araddr=%h want 1 0 90", arvalid, awvalid, araddr);
    end
    slave_idle();
  endtask

  initial begin
    test_reset();
    test_write_fast();
    test_write_wait();
    test_read();
    test_errors();
    test_rsp_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/m_axil_rw.md
# m_axil_rw

Parametrised AXI4-Lite master that replaces the write-only master with full write and read support. It accepts one command at a time from a local valid/ready command port and drives the AW/W/B or AR/R channels. It returns each completion on a valid/ready response port and keeps a saturating count of non-OKAY responses. It sits between local control logic and any AXI4-Lite slave, including the existing `s_axi` register slave.

## Interface
Parameters:
- ADDR_W, 32, address width of command and AW/AR channels
- DATA_W, 32, data width; must be 32 or 64; strobe width is DATA_W/8
- ERRCNT_W, 8, width of the saturating error counter

Ports:
- i_clk  in  1  single clock; all logic is on the rising edge
- i_resetn  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid and ready are both high
- i_cmd_wr  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDR_W  byte address, passed unchanged
- i_cmd_data  in  DATA_W  write data, ignored on reads
- i_cmd_strb  in  DATA_W/8  write strobes, ignored on reads
- o_rsp_valid  out  1  completion present
- i_rsp_ready  in  1  completion consumed
- o_rsp_wr  out  1  completion belongs to a write
- o_rsp_data  out  DATA_W  read data; 0 for writes
- o_rsp_resp  out  2  BRESP or RRESP as received
- o_err_cnt  out  ERRCNT_W  saturating count of responses with resp != 2'b00
- m_axi_awvalid  out  1; m_axi_awready  in  1; m_axi_awaddr  out  ADDR_W
- m_axi_wvalid  out  1; m_axi_wready  in  1; m_axi_wdata  out  DATA_W; m_axi_wstrb  out  DATA_W/8
- m_axi_bvalid  in  1; m_axi_bready  out  1; m_axi_bresp  in  2
- m_axi_arvalid  out  1; m_axi_arready  in  1; m_axi_araddr  out  ADDR_W
- m_axi_rvalid  in  1; m_axi_rready  out  1; m_axi_rdata  in  DATA_W; m_axi_rresp  in  2

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- All outputs are registered. On reset every output is 0 and the state is IDLE.
- IDLE: o_cmd_ready=1. On accept, capture addr/data/strb/wr.
  - A write goes to WR_REQ with awvalid=1 and wvalid=1.
  - A read goes to RD_REQ with arvalid=1.
- WR_REQ: AW and W complete independently.
  - awvalid drops on the edge where awready=1 is sampled; wvalid drops on the edge where wready=1 is sampled.
  - Each valid, once raised, is held with stable payload until its own handshake.
  - When both handshakes are done, go to WR_RESP with bready=1. Both handshakes may land in the same cycle.
- WR_RESP: on the bvalid handshake, drop bready, latch bresp, set o_rsp_wr=1 and o_rsp_data=0, then go to RSP.
- RD_REQ: on the arvalid/arready handshake, drop arvalid, raise rready and go to RD_RESP.
- RD_RESP: on the rvalid handshake, drop rready, latch rdata/rresp, set o_rsp_wr=0, then go to RSP.
- RSP: o_rsp_valid=1 with stable fields until i_rsp_ready=1 is sampled, then go to IDLE.
- Error counter:
  - o_err_cnt increments by 1 on the edge where a B or R response with resp != 0 is latched.
  - It saturates at 2^ERRCNT_W-1 and is cleared only by reset.
- Only one transaction is outstanding at a time. The block issues no AXI activity while in RSP or IDLE.
- B/R beats arriving while bready/rready is low are not sampled; AXI requires the slave to hold them.
- Reset assertion mid-transaction:
  - All outputs go to 0 immediately, asynchronously; the in-flight command and response are lost.
  - The AXI slave must be reset by the same signal.

## Timing
- Cmd accepted at edge N, so awvalid/wvalid/arvalid are high from edge N.
- o_cmd_ready is low from edge N until the edge at which the response is consumed. It is high again in the cycle after the rsp handshake.
- Write best case (awready, wready and bvalid all high at first opportunity):
  - AW/W handshake at edge N+1, bready high from N+1.
  - B handshake at edge N+2.
  - o_rsp_valid high from N+2; next cmd can be accepted at edge N+4 if i_rsp_ready=1.
- Read best case: AR handshake at N+1, R handshake at N+2, o_rsp_valid from N+2.
- Each extra cycle of slave ready/valid delay adds exactly one cycle.
- In RSP, rsp_valid is held with no limit while i_rsp_ready is low.

## Test plan
- Write with slave always ready: cmd addr=0x10, data=0x5, strb=0xF.
  - Required: awaddr=0x10, wdata=0x5, wstrb=0xF.
  - Required: rsp_valid at N+2 with rsp_wr=1, resp=0, err_cnt=0.
- Write with awready at N+1 but wready held low until N+4.
  - Required: awvalid low after N+1; wvalid held high with wdata stable until N+4.
  - Required: bready rises only after N+4.
- Read of addr 0x8 with the slave returning rdata=0xA5A5_0001 after 3 wait cycles.
  - Required: rsp_data=0xA5A5_0001, rsp_wr=0, resp=0.
- Slave returns bresp=2'b10, then rresp=2'b11.
  - Required: each resp is reported as received; err_cnt goes to 1, then 2.
  - With ERRCNT_W=2 and five errors, err_cnt stays at 3.
- Hold i_rsp_ready low for 5 cycles.
  - Required: rsp_valid and all rsp fields are stable, cmd_ready=0, no AXI valids are asserted.
- Deassert i_resetn while in WR_REQ.
  - Required: all outputs are 0 in the same cycle.
  - After release: IDLE, cmd_ready=1 at the first edge, err_cnt=0.
